// File: rtl/fsm_event_arbiter.sv
// Round-robin arbiter sharing one external 3-state x/y FSM between NREQ requesters,
// with burst locking, lock timeout and a fixed two-cycle response pipeline.
module fsm_event_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned LOCK_TMO = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_ev,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [1:0]        rsp_out,
  output logic              fsm_x,
  output logic              fsm_y,
  input  logic [1:0]        fsm_out,
  output logic              busy,
  output logic              lock_abort
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(LOCK_TMO + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [CW-1:0]   idle_cnt, idle_cnt_nxt;
  logic            acc;
  logic [IW-1:0]   acc_id;
  logic [IW-1:0]   cand;
  logic [1:0]      ev_sel;
  logic            lock_sel;
  logic            timeout;
  logic            s1_vld, s2_vld;
  logic [IW-1:0]   s1_id, s2_id;

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] i);
    return IW'((32'(i) + 32'd1) % NREQ);
  endfunction

  always_comb begin
    req_ready    = '0;
    acc          = 1'b0;
    acc_id       = '0;
    cand         = '0;
    timeout      = 1'b0;
    ev_sel       = 2'b00;
    lock_sel     = 1'b0;
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    idle_cnt_nxt = idle_cnt;

    case (state)
      IDLE: begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          cand = IW'((32'(rr_ptr) + k) % NREQ);
          if (!acc && req_valid[cand]) begin
            acc    = 1'b1;
            acc_id = cand;
          end
        end
      end
      LOCKED: begin
        // The timeout cycle grants nobody, not even the owner.
        if (idle_cnt == CW'(LOCK_TMO)) begin
          timeout = 1'b1;
        end else if (req_valid[owner]) begin
          acc    = 1'b1;
          acc_id = owner;
        end
      end
      default: ;
    endcase

    if (acc) req_ready[acc_id] = 1'b1;

    for (int unsigned i = 0; i < NREQ; i++) begin
      if (acc_id == IW'(i)) begin
        ev_sel   = req_ev[2*i +: 2];
        lock_sel = req_lock[i];
      end
    end

    case (state)
      IDLE: begin
        if (acc) begin
          rr_ptr_nxt = next_id(acc_id);
          if (lock_sel) begin
            state_nxt    = LOCKED;
            owner_nxt    = acc_id;
            idle_cnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (timeout) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = next_id(owner);
        end else if (acc) begin
          if (lock_sel) begin
            idle_cnt_nxt = '0;
          end else begin
            state_nxt  = IDLE;
            rr_ptr_nxt = next_id(owner);
          end
        end else begin
          idle_cnt_nxt = idle_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      idle_cnt <= '0;
      s1_vld   <= 1'b0;
      s1_id    <= '0;
      s2_vld   <= 1'b0;
      s2_id    <= '0;
      fsm_x    <= 1'b0;
      fsm_y    <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      idle_cnt <= idle_cnt_nxt;
      s1_vld   <= acc;
      s1_id    <= acc_id;
      fsm_x    <= acc & ev_sel[0];
      fsm_y    <= acc & ev_sel[1];
      s2_vld   <= s1_vld;
      s2_id    <= s1_id;
    end
  end

  // fsm_out already reflects the stage-1 event in stage 2, so it is forwarded directly.
  always_comb begin
    rsp_valid = '0;
    if (s2_vld) rsp_valid[s2_id] = 1'b1;
    rsp_out    = s2_vld ? fsm_out : 2'b00;
    busy       = (state == LOCKED) | s1_vld | s2_vld;
    lock_abort = timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(req_ready));
      assert ($onehot0(rsp_valid));
    end
  end

endmodule

// File: tb/tb_fsm_event_arbiter.sv
// Bench for fsm_event_arbiter: directed scenarios then random traffic, all checked
// against a cycle-level reference of the arbitration rules and an event-fold FSM model.
module tb_fsm_event_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_lock, req_ready, rsp_valid;
  logic [2*NREQ-1:0] req_ev;
  logic [1:0]        rsp_out, fsm_out;
  logic              fsm_x, fsm_y, busy, lock_abort;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_event_arbiter #(.NREQ(NREQ), .LOCK_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ev(req_ev), .req_lock(req_lock),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_out(rsp_out), .fsm_x(fsm_x),
    .fsm_y(fsm_y), .fsm_out(fsm_out), .busy(busy), .lock_abort(lock_abort)
  );

  // Shared FSM stand-in: codes 00/10/01, y has priority over x.
  logic [1:0] env_st;
  always @(posedge clk) begin
    if (rst)        env_st <= 2'b00;
    else if (fsm_y) env_st <= (env_st == 2'b10) ? 2'b00 : 2'b01;
    else if (fsm_x) env_st <= (env_st == 2'b00) ? 2'b10 : 2'b01;
  end
  assign fsm_out = env_st;

  // Reference: state index 0/1/2 with transition tables.
  logic [1:0] out_code [3] = '{2'b00, 2'b10, 2'b01};
  int         y_tbl    [3] = '{2, 0, 2};
  int         x_tbl    [3] = '{1, 2, 2};

  typedef struct { int c; int id; logic [1:0] ev; } beat_t;
  beat_t pq[$];
  bit    m_locked;
  int    m_owner, m_ptr, m_idle, m_fsm, cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(output int g);
    logic [NREQ-1:0] er, erv;
    logic [1:0]      ero;
    logic            ex, ey, eb, ea;
    int              idx;
    #1;
    g = -1;
    if (rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_fsm = 0;
      pq.delete();
    end else begin
      ea = m_locked && (m_idle == TMO);
      if (!m_locked) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end else if (!ea && req_valid[m_owner]) begin
        g = m_owner;
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      ex = 0; ey = 0; erv = '0; ero = 2'b00; eb = m_locked;
      foreach (pq[j]) begin
        if (pq[j].c == cyc - 1) begin ex = pq[j].ev[0]; ey = pq[j].ev[1]; eb = 1; end
        if (pq[j].c == cyc - 2) begin
          erv[pq[j].id] = 1'b1;
          if (pq[j].ev[1])      m_fsm = y_tbl[m_fsm];
          else if (pq[j].ev[0]) m_fsm = x_tbl[m_fsm];
          ero = out_code[m_fsm];
          eb  = 1;
        end
      end
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(erv));
      chk("rsp_out", 32'(rsp_out), 32'(ero));
      chk("fsm_x", 32'(fsm_x), 32'(ex));
      chk("fsm_y", 32'(fsm_y), 32'(ey));
      chk("busy", 32'(busy), 32'(eb));
      chk("lock_abort", 32'(lock_abort), 32'(ea));
      while (pq.size() > 0 && pq[0].c <= cyc - 2) void'(pq.pop_front());
      if (g >= 0) begin
        pq.push_back('{cyc, g, req_ev[2*g +: 2]});
        if (!m_locked) begin
          m_ptr = (g + 1) % NREQ;
          if (req_lock[g]) begin m_locked = 1; m_owner = g; m_idle = 0; end
        end else if (req_lock[g]) begin
          m_idle = 0;
        end else begin
          m_locked = 0; m_ptr = (m_owner + 1) % NREQ;
        end
      end else if (m_locked) begin
        if (ea) begin m_locked = 0; m_ptr = (m_owner + 1) % NREQ; end
        else    m_idle++;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_ev = '0; req_lock = '0;
  endtask

  task automatic do_reset();
    int g;
    rst = 1'b1;
    idle_inputs();
    step(g); adv();
    step(g); adv();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    int g;
    idle_inputs();
    for (int i = 0; i < n; i++) begin step(g); adv(); end
  endtask

  initial begin
    int              g;
    logic [NREQ-1:0] held;
    cyc = 0;
    idle_inputs();
    do_reset();

    // Reset state
    step(g);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_out", 32'(rsp_out), 32'h0);
    chk("rst_fsm_x", 32'(fsm_x), 32'h0);
    chk("rst_lock_abort", 32'(lock_abort), 32'h0);
    adv();

    // Single x event from req0
    req_valid = 4'b0001; req_ev = 8'b00_00_00_01;
    step(g); chk("t1_ready", 32'(req_ready), 32'h1); adv();
    idle_inputs();
    step(g); chk("t1_fsm_x", 32'(fsm_x), 32'h1); adv();
    step(g);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_out", 32'(rsp_out), 32'h2);
    adv();

    // Round-robin rotation with everyone valid
    do_reset();
    req_valid = 4'b1111; req_ev = '0;
    for (int k = 0; k < 6; k++) begin
      step(g);
      chk("t2_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) chk("t2_rsp", 32'(rsp_valid), 32'(1 << ((k - 2) % 4)));
      adv();
    end
    drain(3);

    // Locked burst from req2 while req1 waits
    do_reset();
    req_valid = 4'b0100; req_ev = 8'b00_01_00_00; req_lock = 4'b0100;
    step(g); chk("t3_beat0", 32'(req_ready), 32'h4); adv();
    req_valid = 4'b0110;
    step(g); chk("t3_beat1", 32'(req_ready), 32'h4); adv();
    req_ev = 8'b00_10_00_00; req_lock = 4'b0000;
    step(g); chk("t3_beat2", 32'(req_ready), 32'h4); adv();
    step(g); chk("t3_req1", 32'(req_ready), 32'h2); adv();
    drain(3);

    // Lock timeout
    do_reset();
    req_valid = 4'b0110; req_ev = 8'b00_00_01_00; req_lock = 4'b0010;
    step(g); chk("t4_lock", 32'(req_ready), 32'h2); adv();
    req_valid = 4'b0100; req_lock = '0; req_ev = '0;
    for (int k = 0; k < TMO; k++) begin
      step(g);
      chk("t4_wait_ready", 32'(req_ready), 32'h0);
      chk("t4_wait_abort", 32'(lock_abort), 32'h0);
      adv();
    end
    step(g);
    chk("t4_abort", 32'(lock_abort), 32'h1);
    chk("t4_abort_ready", 32'(req_ready), 32'h0);
    adv();
    step(g); chk("t4_req2", 32'(req_ready), 32'h4); adv();
    drain(3);

    // Reset with an event in flight
    do_reset();
    req_valid = 4'b1000; req_ev = 8'b01_00_00_00;
    step(g); chk("t5_grant", 32'(req_ready), 32'h8); adv();
    rst = 1'b1; idle_inputs();
    step(g); adv();
    rst = 1'b0;
    step(g);
    chk("t5_rsp_killed", 32'(rsp_valid), 32'h0);
    chk("t5_fsm_x", 32'(fsm_x), 32'h0);
    adv();
    req_valid = 4'b1001; req_ev = '0;
    step(g); chk("t5_ptr0", 32'(req_ready), 32'h1); adv();
    drain(3);

    // x+y, then y, then x from the reset state
    do_reset();
    req_valid = 4'b0001; req_ev = 8'b00_00_00_11;
    step(g); adv();
    req_ev = 8'b00_00_00_10;
    step(g); adv();
    req_ev = 8'b00_00_00_01;
    step(g); chk("t6_rsp_xy", 32'(rsp_out), 32'h1); adv();
    idle_inputs();
    step(g); chk("t6_rsp_y", 32'(rsp_out), 32'h1); adv();
    step(g); chk("t6_rsp_x", 32'(rsp_out), 32'h1); adv();
    drain(2);

    // Random traffic honouring the hold-while-not-ready rule
    held = '0;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      for (int i = 0; i < NREQ; i++) begin
        if (!held[i]) begin
          req_valid[i]      = ($urandom_range(0, 99) < 55);
          req_ev[2*i +: 2]  = 2'($urandom_range(0, 3));
          req_lock[i]       = ($urandom_range(0, 99) < 35);
        end
      end
      step(g);
      held = rst ? '0 : (req_valid & ~req_ready);
      adv();
    end
    rst = 1'b0;
    drain(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
